// File: rtl/if_fetch_align.sv
// Instruction-fetch front end for an RV32IC core.
// Fetches 32-bit words from a 1-cycle-latency instruction memory. Keeps a
// 4-entry halfword buffer and presents whole 16/32-bit instructions at any
// halfword alignment over a valid/ready handshake. Redirects flush the
// buffer and any in-flight word.
module if_fetch_align #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc,
  output logic                  instr_is_c
);

  localparam logic [ADDR_WIDTH-1:0] RESET_WORD = RESET_PC[ADDR_WIDTH+1:2];
  localparam logic [31:0]           RESET_BPC  = {RESET_PC[31:1], 1'b0};

  // fetch state
  logic [ADDR_WIDTH-1:0] fetch_word;
  logic                  resp_valid;   // word requested last cycle arrives now
  logic                  skip_low;     // next arriving word starts at its high half

  // halfword buffer, hb[0] is the head
  logic [3:0][15:0] hb, hb_n;
  logic [2:0]       count;
  logic [31:0]      buf_pc;

  // datapath helpers
  logic       compressed;
  logic       fire;
  logic       issue;
  logic [2:0] consumed;
  logic [2:0] inserted;
  logic [2:0] remaining;
  logic [2:0] projected;
  logic [15:0] ins_lo, ins_hi;

  // bit 0 of a redirect target is meaningless for halfword-aligned PCs
  logic unused_pc0;
  assign unused_pc0 = redirect_pc[0];

  // head decode: depends only on buffer state, never on instr_ready
  always_comb begin
    compressed  = (hb[0][1:0] != 2'b11);
    instr_valid = ((count >= 3'd1) && compressed) ||
                  ((count >= 3'd2) && !compressed);
    instr_is_c  = instr_valid && compressed;
    instr       = compressed ? {16'h0000, hb[0]} : {hb[1], hb[0]};
    instr_pc    = buf_pc;
    imem_addr   = fetch_word;
  end

  // handshake, buffer occupancy bookkeeping and request decision
  always_comb begin
    fire      = instr_valid && instr_ready && !redirect_valid;
    consumed  = fire ? (compressed ? 3'd1 : 3'd2) : 3'd0;
    inserted  = resp_valid ? (skip_low ? 3'd1 : 3'd2) : 3'd0;
    remaining = count - consumed;
    projected = remaining + inserted;
    // requesting only when at most 2 halfwords will be held keeps room for
    // the word that lands next cycle, so the buffer never exceeds 4
    issue     = !redirect_valid && (projected <= 3'd2);
  end

  // next buffer contents: shift out the consumed head, append the response
  always_comb begin
    hb_n   = hb;
    ins_lo = skip_low ? imem_dout[31:16] : imem_dout[15:0];
    ins_hi = imem_dout[31:16];
    case (consumed)
      3'd1:    hb_n = {16'h0000, hb[3:1]};
      3'd2:    hb_n = {32'h0000_0000, hb[3:2]};
      default: hb_n = hb;
    endcase
    // a response only lands when at most 2 halfwords were held, so
    // remaining+1 always stays inside the buffer
    if (resp_valid) begin
      for (int i = 0; i < 4; i++) begin
        if (3'(i) == remaining)
          hb_n[i] = ins_lo;
        if (!skip_low && (3'(i) == remaining + 3'd1))
          hb_n[i] = ins_hi;
      end
    end
  end

  // state registers; redirect flushes everything including the word in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_word <= RESET_WORD;
      resp_valid <= 1'b0;
      skip_low   <= RESET_PC[1];
      hb         <= '0;
      count      <= 3'd0;
      buf_pc     <= RESET_BPC;
    end else if (redirect_valid) begin
      fetch_word <= redirect_pc[ADDR_WIDTH+1:2];
      resp_valid <= 1'b0;
      skip_low   <= redirect_pc[1];
      count      <= 3'd0;
      buf_pc     <= {redirect_pc[31:1], 1'b0};
    end else begin
      hb         <= hb_n;
      count      <= projected;
      resp_valid <= issue;
      if (issue)
        fetch_word <= fetch_word + ADDR_WIDTH'(1);
      if (fire)
        buf_pc <= buf_pc + (compressed ? 32'd2 : 32'd4);
      if (resp_valid)
        skip_low <= 1'b0;
    end
  end

  // buffer occupancy bound
  a_count_bound: assert property (@(posedge clk) disable iff (!rst_n) count <= 3'd4);

endmodule

// File: tb/tb_if_fetch_align.sv
// Self-checking bench for if_fetch_align: directed scenarios plus a
// randomized run checked against an instruction-stream reference model.
module tb_if_fetch_align;

  localparam int          AW  = 11;
  localparam logic [31:0] RPC = 32'h0000_0000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_dout;
  logic          redirect_valid = 1'b0;
  logic [31:0]   redirect_pc = 32'h0;
  logic          instr_valid;
  logic          instr_ready = 1'b0;
  logic [31:0]   instr;
  logic [31:0]   instr_pc;
  logic          instr_is_c;

  if_fetch_align #(.ADDR_WIDTH(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .instr_is_c(instr_is_c)
  );

  always #5 clk = ~clk;

  // registered instruction memory, 1-cycle read latency
  logic [31:0] mem [2**AW];
  always @(posedge clk) imem_dout <= mem[imem_addr];

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // reference model: next expected PC of the accepted instruction stream
  logic [31:0] exp_pc;
  int          cyc_n;
  int          idle;
  bit          stall_prev;
  logic [31:0] prev_ins, prev_pc;
  logic [31:0] acc_pc[$];
  logic [31:0] acc_ins[$];
  bit          acc_c[$];
  int          acc_cyc[$];

  function automatic logic [15:0] hw_at(input logic [31:0] pc);
    logic [31:0] w;
    w = mem[pc[AW+1:2]];
    return pc[1] ? w[31:16] : w[15:0];
  endfunction

  // one clock cycle: entered and left at a negedge
  task automatic cyc(input bit rdy, input bit redir, input logic [31:0] rpc);
    logic [15:0] h0;
    logic [31:0] e_ins;
    bit          e_c;
    instr_ready    = rdy;
    redirect_valid = redir;
    redirect_pc    = rpc;
    #1;
    if (stall_prev) begin
      chk("hold_valid", 32'(instr_valid), 32'd1);
      chk("hold_instr", instr, prev_ins);
      chk("hold_pc", instr_pc, prev_pc);
    end
    if (!instr_valid) chk("is_c_gated", 32'(instr_is_c), 32'd0);
    if (instr_valid && rdy && !redir) begin
      h0    = hw_at(exp_pc);
      e_c   = (h0[1:0] != 2'b11);
      e_ins = e_c ? {16'h0000, h0} : {hw_at(exp_pc + 32'd2), h0};
      chk("acc_pc", instr_pc, exp_pc);
      chk("acc_instr", instr, e_ins);
      chk("acc_is_c", 32'(instr_is_c), 32'(e_c));
      acc_pc.push_back(instr_pc);
      acc_ins.push_back(instr);
      acc_c.push_back(instr_is_c);
      acc_cyc.push_back(cyc_n);
      exp_pc = exp_pc + (e_c ? 32'd2 : 32'd4);
    end
    if (redir) exp_pc = {rpc[31:1], 1'b0};
    if (instr_valid || redir) idle = 0;
    else idle++;
    if (idle > 5) begin
      chk("stall_bound", idle, 5);
      idle = 0;
    end
    stall_prev = instr_valid && !rdy && !redir;
    prev_ins   = instr;
    prev_pc    = instr_pc;
    @(negedge clk);
    cyc_n++;
  endtask

  // hold reset, release on a negedge; returns at cycle 0
  task automatic do_reset();
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    rst_n          = 1'b0;
    repeat (2) @(negedge clk);
    rst_n      = 1'b1;
    cyc_n      = 0;
    idle       = 0;
    stall_prev = 1'b0;
    exp_pc     = {RPC[31:1], 1'b0};
    acc_pc.delete();
    acc_ins.delete();
    acc_c.delete();
    acc_cyc.delete();
  endtask

  initial begin
    int n0;
    logic [AW-1:0] a5, a10;
    logic [31:0] w, rpc;
    bit rdy, redir;

    for (int i = 0; i < 2**AW; i++) mem[i] = $urandom;
    mem[0] = 32'h0010_0093;
    mem[1] = 32'h0020_0113;
    mem[2] = 32'h0030_0193;
    mem[3] = 32'h0040_0213;
    mem[32'h41] = 32'h4581_1111;

    // reset state
    rst_n = 1'b0;
    #12;
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_is_c", 32'(instr_is_c), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc", instr_pc, RPC);
    chk("rst_addr", 32'(imem_addr), 32'(RPC[AW+1:2]));

    // back-to-back 32-bit instructions from reset
    do_reset();
    chk("c0_addr", 32'(imem_addr), 32'd0);
    chk("c0_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("c1_addr", 32'(imem_addr), 32'd1);
    chk("c1_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("c2_addr", 32'(imem_addr), 32'd2);
    chk("c2_valid", 32'(instr_valid), 32'd1);
    repeat (5) cyc(1, 0, 0);
    if (acc_pc.size() >= 4) begin
      chk("t1_pc0", acc_pc[0], 32'd0);
      chk("t1_pc1", acc_pc[1], 32'd4);
      chk("t1_pc2", acc_pc[2], 32'd8);
      chk("t1_pc3", acc_pc[3], 32'd12);
      chk("t1_cyc0", acc_cyc[0], 2);
      chk("t1_cyc3", acc_cyc[3], 5);
    end else chk("t1_count", acc_pc.size(), 4);

    // two compressed instructions in one word
    mem[0] = 32'hC501_4505;
    do_reset();
    repeat (6) cyc(1, 0, 0);
    if (acc_pc.size() >= 2) begin
      chk("t2_ins0", acc_ins[0], 32'h0000_4505);
      chk("t2_pc0", acc_pc[0], 32'd0);
      chk("t2_c0", 32'(acc_c[0]), 32'd1);
      chk("t2_ins1", acc_ins[1], 32'h0000_C501);
      chk("t2_pc1", acc_pc[1], 32'd2);
      chk("t2_c1", 32'(acc_c[1]), 32'd1);
    end else chk("t2_count", acc_pc.size(), 2);

    // 32-bit instruction straddling a word boundary
    mem[0] = 32'h0513_4505;
    mem[1] = 32'h4581_0000;
    do_reset();
    repeat (8) cyc(1, 0, 0);
    if (acc_pc.size() >= 3) begin
      chk("t3_ins1", acc_ins[1], 32'h0000_0513);
      chk("t3_pc1", acc_pc[1], 32'd2);
      chk("t3_c1", 32'(acc_c[1]), 32'd0);
      chk("t3_ins2", acc_ins[2], 32'h0000_4581);
      chk("t3_pc2", acc_pc[2], 32'd6);
    end else chk("t3_count", acc_pc.size(), 3);
    // redirect onto the straddler: low half alone must not be valid
    cyc(1, 1, 32'h0000_0002);
    chk("sd_r1_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("sd_r2_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("sd_r3_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("sd_r4_valid", 32'(instr_valid), 32'd1);
    chk("sd_r4_instr", instr, 32'h0000_0513);
    chk("sd_r4_pc", instr_pc, 32'h0000_0002);
    repeat (4) cyc(1, 0, 0);

    // redirect into the high half of word 0x41
    cyc(1, 1, 32'h0000_0106);
    chk("rd_r1_addr", 32'(imem_addr), 32'h41);
    chk("rd_r1_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("rd_r2_valid", 32'(instr_valid), 32'd0);
    cyc(1, 0, 0);
    chk("rd_r3_valid", 32'(instr_valid), 32'd1);
    chk("rd_r3_pc", instr_pc, 32'h0000_0106);
    chk("rd_r3_instr", instr, 32'h0000_4581);
    n0 = acc_pc.size();
    cyc(1, 0, 0);
    if (acc_pc.size() > n0) chk("rd_first_pc", acc_pc[n0], 32'h0000_0106);
    else chk("rd_accept", acc_pc.size(), n0 + 1);

    // long back-pressure: fetching stops, outputs hold, stream resumes intact
    repeat (3) cyc(1, 0, 0);
    a5 = '0;
    for (int k = 0; k < 10; k++) begin
      cyc(0, 0, 0);
      if (k == 5) a5 = imem_addr;
    end
    a10 = imem_addr;
    chk("stall_addr", 32'(a10), 32'(a5));
    n0 = acc_pc.size();
    repeat (20) cyc(1, 0, 0);
    chk("resume_progress", 32'(acc_pc.size() - n0 >= 10), 32'd1);

    // asynchronous reset between edges
    @(posedge clk);
    #2;
    chk("ar_pre_valid", 32'(instr_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(instr_valid), 32'd0);
    chk("ar_is_c", 32'(instr_is_c), 32'd0);
    chk("ar_pc", instr_pc, RPC);
    chk("ar_addr", 32'(imem_addr), 32'(RPC[AW+1:2]));
    do_reset();
    repeat (6) cyc(1, 0, 0);
    if (acc_pc.size() >= 1) chk("ar_restart_pc", acc_pc[0], RPC);
    else chk("ar_restart_count", acc_pc.size(), 1);

    // randomized run with a mix of C and 32-bit encodings
    for (int i = 0; i < 2**AW; i++) begin
      w = $urandom;
      if ($urandom_range(1, 0) == 1) w[1:0] = 2'b11;
      if ($urandom_range(1, 0) == 1) w[17:16] = 2'b11;
      mem[i] = w;
    end
    do_reset();
    for (int it = 0; it < 3000; it++) begin
      rdy   = ($urandom_range(3, 0) != 0);
      redir = ($urandom_range(15, 0) == 0);
      rpc   = $urandom;
      if ($urandom_range(3, 0) == 0) rpc = 32'hFFFF_FFE0 | {27'h0, rpc[4:0]};
      cyc(rdy, redir, rpc);
      if (it % 700 == 699) begin
        @(posedge clk);
        #4;
        rst_n = 1'b0;
        #1;
        chk("rr_valid", 32'(instr_valid), 32'd0);
        do_reset();
      end
    end
    chk("rand_progress", 32'(acc_pc.size() > 100), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
